// File: rtl/fft_in_buf_pkg.sv
// Shared defaults and state encodings for the FFT input ping-pong buffer.
// Optional bit-reversed readout: FFT_IN_BUF_BITREV_EN.
package fft_in_buf_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 8;
   localparam int FFT_PTS    = 1 << ADDR_W_DEF;

   typedef enum logic [1:0] {
      BK_EMPTY   = 2'd0,
      BK_FILLING = 2'd1,
      BK_FULL    = 2'd2,
      BK_READING = 2'd3
   } bank_st_e;

   typedef enum logic [1:0] {
      RD_IDLE = 2'd0,
      RD_RUN  = 2'd1,
      RD_LAST = 2'd2
   } rd_st_e;

endpackage

// File: rtl/fft_in_buf_if.sv
// ADC-side write strobe and FFT-side frame stream of the input buffer.
// Master drives samples and read requests; slave is the buffer.
interface fft_in_buf_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 8
);
   logic              iWR_EN;
   logic [DATA_W-1:0] iDATA;
   logic              iRD_START;
   logic              oFRAME_RDY;
   logic [DATA_W-1:0] oDATA;
   logic              oVALID;
   logic              oLAST;
   logic [ADDR_W-1:0] oIDX;
   logic              oOVF;

   modport master (
      output iWR_EN, iDATA, iRD_START,
      input  oFRAME_RDY, oDATA, oVALID,
      input  oLAST, oIDX, oOVF
   );

   modport slave (
      input  iWR_EN, iDATA, iRD_START,
      output oFRAME_RDY, oDATA, oVALID,
      output oLAST, oIDX, oOVF
   );
endinterface

// File: rtl/fft_in_buf_dpram.sv
// Simple dual-port sample RAM, one write port and one registered read port.
// The read register clears when no read is issued so idle output is zero.
module fft_dpram #(
   parameter int DATA_W = 16,
   parameter int AW     = 9
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [AW-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              rd_en_i,
   input  logic [AW-1:0]     rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);
   logic [DATA_W-1:0] mem_q [2**AW];
   logic [DATA_W-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)      rd_data_q <= '0;
      else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
      else              rd_data_q <= '0;
   end

   assign rd_data_o = rd_data_q;
endmodule

// File: rtl/fft_in_buf.sv
// Ping-pong frame buffer between ADC samples and the FFT core.
// Define FFT_IN_BUF_BITREV_EN to stream frames in bit-reversed order.
module fft_in_buf
   import fft_in_buf_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic         iCLK,
   input  logic         iRESET,
   fft_in_buf_if.slave  bus
);
   bank_st_e          bank_q [2];
   bank_st_e          bank_d [2];
   logic              wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              ovf_q, ovf_d;
   logic              frame_rdy_q, frame_rdy_d;
   logic              wr_fire;

   rd_st_e            rd_state_q;
   logic              rd_bank_q, rd_next_q, rd_next_d;
   logic [ADDR_W-1:0] k_q, addr_k, idx_q;
   logic              valid_q, last_q;
   logic              rd_accept, rd_release, rd_idle_d;

   // Release, then read claim, then writer: a waiting writer sees
   // a bank freed by this cycle's release.
   always_comb begin
      bank_d     = bank_q;
      wr_bank_d  = wr_bank_q;
      wr_ptr_d   = wr_ptr_q;
      ovf_d      = ovf_q;
      wr_fire    = 1'b0;
      rd_accept  = (rd_state_q == RD_IDLE) && bus.iRD_START && frame_rdy_q;
      rd_release = (rd_state_q == RD_LAST);
      if (rd_release) bank_d[rd_bank_q] = BK_EMPTY;
      if (rd_accept)  bank_d[rd_next_q] = BK_READING;
      if (bank_d[wr_bank_q] == BK_EMPTY) bank_d[wr_bank_q] = BK_FILLING;
      if (bus.iWR_EN) begin
         if (bank_d[wr_bank_q] == BK_FILLING) begin
            wr_fire  = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (wr_ptr_q == '1) begin
               bank_d[wr_bank_q] = BK_FULL;
               wr_bank_d         = ~wr_bank_q;
               if (bank_d[~wr_bank_q] == BK_EMPTY)
                  bank_d[~wr_bank_q] = BK_FILLING;
            end
         end else begin
            ovf_d = 1'b1;
         end
      end
      rd_next_d   = rd_next_q ^ rd_accept;
      rd_idle_d   = rd_release
                 || ((rd_state_q == RD_IDLE) && !rd_accept);
      frame_rdy_d = rd_idle_d && (bank_d[rd_next_d] == BK_FULL);
   end

   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         bank_q[0]   <= BK_FILLING;
         bank_q[1]   <= BK_EMPTY;
         wr_bank_q   <= 1'b0;
         wr_ptr_q    <= '0;
         ovf_q       <= 1'b0;
         frame_rdy_q <= 1'b0;
      end else begin
         bank_q      <= bank_d;
         wr_bank_q   <= wr_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         ovf_q       <= ovf_d;
         frame_rdy_q <= frame_rdy_d;
      end
   end

`ifdef FFT_IN_BUF_BITREV_EN
   always_comb begin
      addr_k = '0;
      for (int i = 0; i < ADDR_W; i++)
         addr_k[i] = k_q[ADDR_W-1-i];
   end
`else
   assign addr_k = k_q;
`endif

   // Frames are filled alternately, so the oldest full bank alternates too.
   always_ff @(posedge iCLK) begin
      if (!iRESET) begin
         rd_state_q <= RD_IDLE;
         rd_bank_q  <= 1'b0;
         rd_next_q  <= 1'b0;
         k_q        <= '0;
         valid_q    <= 1'b0;
         last_q     <= 1'b0;
         idx_q      <= '0;
      end else begin
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         idx_q     <= '0;
         rd_next_q <= rd_next_d;
         unique case (rd_state_q)
            RD_IDLE: begin
               if (rd_accept) begin
                  rd_state_q <= RD_RUN;
                  rd_bank_q  <= rd_next_q;
                  k_q        <= '0;
               end
            end
            RD_RUN: begin
               valid_q <= 1'b1;
               idx_q   <= addr_k;
               last_q  <= (k_q == '1);
               k_q     <= k_q + 1'b1;
               if (k_q == '1) rd_state_q <= RD_LAST;
            end
            RD_LAST: rd_state_q <= RD_IDLE;
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   fft_dpram #(
      .DATA_W (DATA_W),
      .AW     (ADDR_W + 1)
   ) u_ram (
      .clk_i     (iCLK),
      .rst_ni    (iRESET),
      .wr_en_i   (wr_fire),
      .wr_addr_i ({wr_bank_q, wr_ptr_q}),
      .wr_data_i (bus.iDATA),
      .rd_en_i   (rd_state_q == RD_RUN),
      .rd_addr_i ({rd_bank_q, addr_k}),
      .rd_data_o (bus.oDATA)
   );

   assign bus.oFRAME_RDY = frame_rdy_q;
   assign bus.oVALID     = valid_q;
   assign bus.oLAST      = last_q;
   assign bus.oIDX       = idx_q;
   assign bus.oOVF       = ovf_q;
endmodule

// File: tb/tb_fft_in_buf.sv
// Directed bench for fft_in_buf with an expected-sample scoreboard.
// Expected read order follows FFT_IN_BUF_BITREV_EN when it is defined.
module tb_fft_in_buf;

   typedef struct {
      logic [15:0] d;
      logic [7:0]  i;
      logic        l;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   n_valid = 0;
   exp_t exp_q[$];

   fft_in_buf_if #(.DATA_W(16), .ADDR_W(8)) bus ();

   fft_in_buf dut (
      .iCLK   (clk),
      .iRESET (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] order(input int k);
      logic [7:0] kk;
      logic [7:0] r;
      kk = 8'(k);
      r  = kk;
`ifdef FFT_IN_BUF_BITREV_EN
      for (int b = 0; b < 8; b++) r[b] = kk[7-b];
`endif
      return r;
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (bus.oVALID) begin
               n_valid++;
               check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("sb_data", 32'(bus.oDATA), 32'(e.d));
                  check("sb_idx", 32'(bus.oIDX), 32'(e.i));
                  check("sb_last", 32'(bus.oLAST), 32'(e.l));
               end
            end else begin
               check("idle_out",
                     {13'd0, bus.oLAST, bus.oIDX, bus.oDATA}, 32'd0);
            end
         end
      end
   end

   task automatic do_reset();
      rst_n         = 1'b0;
      bus.iWR_EN    = 1'b0;
      bus.iDATA     = '0;
      bus.iRD_START = 1'b0;
      exp_q.delete();
      step();
      step();
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_rdy", 32'(bus.oFRAME_RDY), 32'd0);
      check("rst_valid", 32'(bus.oVALID), 32'd0);
      check("rst_last", 32'(bus.oLAST), 32'd0);
      check("rst_data", 32'(bus.oDATA), 32'd0);
      check("rst_idx", 32'(bus.oIDX), 32'd0);
      check("rst_ovf", 32'(bus.oOVF), 32'd0);
      step();
   endtask

   task automatic write_ramp(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         bus.iWR_EN = 1'b1;
         bus.iDATA  = 16'(base + i);
         step();
      end
      bus.iWR_EN = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      for (int i = 0; i < 2000; i++) begin
         if (bus.oFRAME_RDY) break;
         step();
      end
      check(tag, 32'(bus.oFRAME_RDY), 32'd1);
   endtask

   task automatic push_frame(input int base);
      exp_t e;
      for (int k = 0; k < 256; k++) begin
         e.i = order(k);
         e.d = 16'(base + int'(e.i));
         e.l = (k == 255);
         exp_q.push_back(e);
      end
   endtask

   task automatic read_frame(input int base);
      wait_ready("frame_rdy");
      push_frame(base);
      n_valid = 0;
      bus.iRD_START = 1'b1;
      step();
      bus.iRD_START = 1'b0;
      @(negedge clk);
      check("lat_t1_valid", 32'(bus.oVALID), 32'd0);
      check("rdy_drop", 32'(bus.oFRAME_RDY), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("lat_t2_valid", 32'(bus.oVALID), 32'd1);
      @(posedge clk);
      #1;
      bus.iRD_START = 1'b1;
      step();
      bus.iRD_START = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      repeat (6) step();
      check("frame_count", 32'(n_valid), 32'd256);
   endtask

   initial begin : stim
      int nw;
      int fs;
      bus.iWR_EN    = 1'b0;
      bus.iDATA     = '0;
      bus.iRD_START = 1'b0;
      do_reset();

      // read request with nothing buffered
      n_valid = 0;
      bus.iRD_START = 1'b1;
      step();
      bus.iRD_START = 1'b0;
      repeat (5) step();
      check("start_ignored", 32'(n_valid), 32'd0);

      // single ramp frame
      write_ramp(0, 256);
      read_frame(0);
      check("ramp_ovf", 32'(bus.oOVF), 32'd0);

      // overflow after both banks fill
      do_reset();
      write_ramp(0, 512);
      check("ovf_512", 32'(bus.oOVF), 32'd0);
      write_ramp(512, 1);
      check("ovf_513", 32'(bus.oOVF), 32'd1);
      write_ramp(513, 255);
      read_frame(0);
      read_frame(256);
      check("ovf_sticky", 32'(bus.oOVF), 32'd1);

      // streaming: one sample per 4 cycles, read as soon as ready
      do_reset();
      nw = 0;
      fs = 0;
      for (int c = 0; c < 6000; c++) begin
         if (nw == 1024 && fs == 4 && exp_q.size() == 0) break;
         bus.iWR_EN = (nw < 1024) && (c % 4 == 0);
         bus.iDATA  = 16'(nw);
         if (bus.iWR_EN) nw++;
         bus.iRD_START = (fs < 4) && bus.oFRAME_RDY;
         if (bus.iRD_START) begin
            push_frame(fs * 256);
            fs++;
         end
         step();
      end
      bus.iWR_EN    = 1'b0;
      bus.iRD_START = 1'b0;
      check("stream_frames", 32'(fs), 32'd4);
      check("stream_drain", 32'(exp_q.size()), 32'd0);
      check("stream_ovf", 32'(bus.oOVF), 32'd0);

      // reset in the middle of a read
      do_reset();
      write_ramp(1000, 256);
      wait_ready("mid_rdy");
      push_frame(1000);
      n_valid = 0;
      bus.iRD_START = 1'b1;
      step();
      bus.iRD_START = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         #1;
         if (n_valid >= 100) break;
      end
      check("mid_count", 32'(n_valid), 32'd100);
      rst_n = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_valid", 32'(bus.oVALID), 32'd0);
      check("mid_data", 32'(bus.oDATA), 32'd0);
      check("mid_idx", 32'(bus.oIDX), 32'd0);
      check("mid_rdy", 32'(bus.oFRAME_RDY), 32'd0);
      check("mid_last", 32'(bus.oLAST), 32'd0);
      step();
      write_ramp(2000, 256);
      read_frame(2000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
